// File: rtl/sensor_node.sv
// sensor_node: serial-link responder that answers NODE_ADDR commands with (data, data^KEY).
// Define NODE_ALARM_EN to add the alarm latch and its (0x00, KEY) priority reply.
module sensor_node #(
  parameter logic [7:0] NODE_ADDR    = 8'h01,
  parameter logic [7:0] KEY          = 8'h37,
  parameter int         CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bus,
  input  logic [7:0] sensor_data,
  input  logic       alarm_in,
  output logic       tx_bus,
  output logic       busy,
  output logic       frame_err,
  output logic       cmd_drop
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [2:0] {T_IDLE, T_GAP, T_START, T_DATA, T_STOP} tstate_t;

  rstate_t       rstate;
  tstate_t       tstate;
  logic          rx_meta, rx, rx_last;
  logic [CW-1:0] rcnt, tcnt;
  logic [2:0]    rbit, tbit;
  logic [7:0]    rsh, tsh, second_byte, data_fix;
  logic          second, alarm_sent, alarm_q;
  logic          rx_tick, tx_tick, hit, reply_done;

  assign rx_tick    = rcnt == (rstate == R_START ? HALF_END : BIT_END);
  assign tx_tick    = tcnt == BIT_END;
  assign hit        = rstate == R_STOP && rx_tick && rx && rsh == NODE_ADDR && rsh != 8'h00;
  assign reply_done = tstate == T_STOP && tx_tick && second;
  // A zero sample would alias the alarm pair, so it is reported as 0x01
  assign data_fix   = sensor_data == 8'h00 ? 8'h01 : sensor_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx        <= 1'b1;
      rx_last   <= 1'b1;
      rstate    <= R_IDLE;
      rcnt      <= '0;
      rbit      <= '0;
      rsh       <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx_bus;
      rx        <= rx_meta;
      rx_last   <= rx;
      frame_err <= 1'b0;
      rcnt      <= rx_tick ? '0 : rcnt + CW'(1);
      case (rstate)
        R_IDLE: begin
          rcnt <= '0;
          if (rx_last && !rx) rstate <= R_START;
        end
        R_START: if (rx_tick) rstate <= rx ? R_IDLE : R_DATA;
        R_DATA: if (rx_tick) begin
          rsh  <= {rx, rsh[7:1]};
          rbit <= rbit + 3'd1;
          if (rbit == 3'd7) rstate <= R_STOP;
        end
        R_STOP: if (rx_tick) begin
          frame_err <= !rx;
          rstate    <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tstate      <= T_IDLE;
      tcnt        <= '0;
      tbit        <= '0;
      tsh         <= '0;
      second_byte <= '0;
      second      <= 1'b0;
      alarm_sent  <= 1'b0;
      tx_bus      <= 1'b1;
      busy        <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      cmd_drop <= hit && busy;
      tcnt     <= (tx_tick || tstate == T_IDLE) ? '0 : tcnt + CW'(1);
      case (tstate)
        T_IDLE: if (hit) begin
          busy        <= 1'b1;
          second      <= 1'b0;
          alarm_sent  <= alarm_q;
          tsh         <= alarm_q ? 8'h00 : data_fix;
          second_byte <= alarm_q ? KEY : data_fix ^ KEY;
          tstate      <= T_GAP;
        end
        T_GAP: if (tx_tick) begin
          tx_bus <= 1'b0;
          tstate <= T_START;
        end
        T_START: if (tx_tick) begin
          tx_bus <= tsh[0];
          tstate <= T_DATA;
        end
        T_DATA: if (tx_tick) begin
          tbit   <= tbit + 3'd1;
          tx_bus <= tbit == 3'd7 ? 1'b1 : tsh[1];
          tsh    <= tsh >> 1;
          if (tbit == 3'd7) tstate <= T_STOP;
        end
        T_STOP: if (tx_tick) begin
          if (second) begin
            busy   <= 1'b0;
            tstate <= T_IDLE;
          end else begin
            second <= 1'b1;
            tsh    <= second_byte;
            tx_bus <= 1'b0;
            tstate <= T_START;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end

`ifdef NODE_ALARM_EN
  // A new request in the clearing cycle wins, so it is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alarm_q <= 1'b0;
    else alarm_q <= alarm_in || (alarm_q && !(reply_done && alarm_sent));
  end
`else
  logic unused_alarm;
  assign alarm_q      = 1'b0;
  assign unused_alarm = alarm_in ^ alarm_sent ^ reply_done;
`endif
endmodule

// File: tb/tb_sensor_node.sv
// tb_sensor_node: vector table, hand sequences and randomized commands checked against a
// behavioural reply model; the serial reply is decoded by an independent UART monitor.
module tb_sensor_node;
  localparam int CPB = 16;
  localparam logic [7:0] ADDR = 8'h01;
  localparam logic [7:0] KEY = 8'h37;
`ifdef NODE_ALARM_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, rx_line = 1'b1, alarm_in = 1'b0;
  logic [7:0] sensor_data = 8'h00;
  logic tx_bus, busy, frame_err, cmd_drop;
  int n_chk = 0, n_fail = 0;
  int busy_cnt = 0, ferr_cnt = 0, drop_cnt = 0, mon_bad = 0;
  logic [7:0] rx_q[$];
  bit m_alarm = 1'b0;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] sd;
    bit         alarm;
    int         n;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t tbl[7];

  sensor_node #(.NODE_ADDR(ADDR), .KEY(KEY), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(rst_n), .rx_bus(rx_line), .sensor_data(sensor_data),
    .alarm_in(alarm_in), .tx_bus(tx_bus), .busy(busy), .frame_err(frame_err),
    .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (frame_err) ferr_cnt++;
    if (cmd_drop) drop_cnt++;
  end

  // Independent 8N1 decoder of the reply line
  always begin
    logic [7:0] b;
    @(negedge tx_bus);
    repeat (CPB / 2) @(negedge clk);
    if (tx_bus !== 1'b0) mon_bad++;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx_bus;
    end
    repeat (CPB) @(negedge clk);
    if (tx_bus !== 1'b1) mon_bad++;
    rx_q.push_back(b);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] cmd, input logic [7:0] sd,
                                output int n, output logic [7:0] e0, output logic [7:0] e1);
    logic [7:0] d;
    d = (sd == 8'h00) ? 8'h01 : sd;
    n = 0; e0 = 8'h00; e1 = 8'h00;
    if (cmd == ADDR && cmd != 8'h00) begin
      n = 2;
      if (m_alarm) begin
        e1 = KEY;
        m_alarm = 1'b0;
      end else begin
        e0 = d;
        e1 = d ^ KEY;
      end
    end
  endfunction

  task automatic pulse_alarm();
    alarm_in = 1'b1;
    @(negedge clk);
    alarm_in = 1'b0;
    m_alarm = m_alarm | AEN;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic settle();
    int i;
    i = 0;
    while (busy && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("busy timeout", int'(busy), 0);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic xact(input string name, input logic [7:0] cmd, input int n,
                      input logic [7:0] e0, input logic [7:0] e1);
    int b0, f0, d0, m0;
    rx_q.delete();
    b0 = busy_cnt; f0 = ferr_cnt; d0 = drop_cnt; m0 = mon_bad;
    send_byte(cmd, 1'b1);
    settle();
    chk({name, " busy cycles"}, busy_cnt - b0, n == 2 ? 21 * CPB : 0);
    chk({name, " frames"}, rx_q.size(), n);
    if (n == 2 && rx_q.size() == 2) begin
      chk({name, " byte0"}, int'(rx_q[0]), int'(e0));
      chk({name, " byte1"}, int'(rx_q[1]), int'(e1));
    end
    chk({name, " frame_err"}, ferr_cnt - f0, 0);
    chk({name, " cmd_drop"}, drop_cnt - d0, 0);
    chk({name, " stop bits"}, mon_bad - m0, 0);
  endtask

  initial begin
    int n, i, b0, f0, d0;
    logic [7:0] e0, e1;

    tbl[0] = '{8'h01, 8'h5A, 1'b0, 2, 8'h5A, 8'h6D};
    tbl[1] = '{8'h02, 8'h5A, 1'b0, 0, 8'h00, 8'h00};
    tbl[2] = '{8'h00, 8'h5A, 1'b0, 0, 8'h00, 8'h00};
    tbl[3] = '{8'h01, 8'h00, 1'b0, 2, 8'h01, 8'h36};
`ifdef NODE_ALARM_EN
    tbl[4] = '{8'h01, 8'h33, 1'b1, 2, 8'h00, 8'h37};
`else
    tbl[4] = '{8'h01, 8'h33, 1'b1, 2, 8'h33, 8'h04};
`endif
    tbl[5] = '{8'h01, 8'h33, 1'b0, 2, 8'h33, 8'h04};
    tbl[6] = '{8'h01, 8'hFF, 1'b0, 2, 8'hFF, 8'hC8};

    repeat (5) @(negedge clk);
    chk("reset tx_bus", int'(tx_bus), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset cmd_drop", int'(cmd_drop), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during the 5th data bit of the first reply byte
    sensor_data = 8'h5A;
    send_byte(ADDR, 1'b1);
    i = 0;
    while (tx_bus && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("mid-reply start bit", int'(tx_bus), 0);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-reply reset tx_bus", int'(tx_bus), 1);
    chk("mid-reply reset busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("mid-reply held tx_bus", int'(tx_bus), 1);
    rst_n = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    m_alarm = 1'b0;
    xact("after reset", ADDR, 2, 8'h5A, 8'h6D);

    for (int k = 0; k < 7; k++) begin
      sensor_data = tbl[k].sd;
      if (tbl[k].alarm) pulse_alarm();
      xact($sformatf("vec%0d", k), tbl[k].cmd, tbl[k].n, tbl[k].e0, tbl[k].e1);
    end
    m_alarm = 1'b0;

    // Stop bit forced low
    rx_q.delete();
    b0 = busy_cnt; f0 = ferr_cnt;
    send_byte(ADDR, 1'b0);
    settle();
    chk("stop low frame_err pulses", ferr_cnt - f0, 1);
    chk("stop low frames", rx_q.size(), 0);
    chk("stop low busy", busy_cnt - b0, 0);

    // Back-to-back matching commands
    sensor_data = 8'hA5;
    model(ADDR, sensor_data, n, e0, e1);
    rx_q.delete();
    b0 = busy_cnt; d0 = drop_cnt;
    send_byte(ADDR, 1'b1);
    send_byte(ADDR, 1'b1);
    settle();
    chk("b2b cmd_drop pulses", drop_cnt - d0, 1);
    chk("b2b frames", rx_q.size(), 2);
    chk("b2b busy cycles", busy_cnt - b0, 21 * CPB);
    if (rx_q.size() == 2) begin
      chk("b2b byte0", int'(rx_q[0]), int'(e0));
      chk("b2b byte1", int'(rx_q[1]), int'(e1));
    end

    // Alarm raised during a data reply is deferred to the next command
    sensor_data = 8'h42;
    model(ADDR, sensor_data, n, e0, e1);
    fork
      xact("alarm mid reply", ADDR, n, e0, e1);
      begin
        repeat (200) @(negedge clk);
        pulse_alarm();
      end
    join
    model(ADDR, sensor_data, n, e0, e1);
    xact("alarm after reply", ADDR, n, e0, e1);

    for (int k = 0; k < 12; k++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 3);
      c = r < 2 ? ADDR : (r == 2 ? 8'h00 : 8'($urandom));
      sensor_data = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) pulse_alarm();
      model(c, sensor_data, n, e0, e1);
      xact($sformatf("rand%0d cmd %0h", k, c), c, n, e0, e1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_node.md
# sensor_node

- Bus-side responder for the arbiter's serial link.
- Receives 8N1 command bytes on the arbiter's transmit line.
- When the byte matches its node address, it answers on the arbiter's receive line with a two-byte packet: data byte, then check byte = data XOR key.
- It can also answer with the alarm packet instead. It is the stage directly downstream of the arbiter's transmitter and upstream of its receiver.

## Interface
Parameters:
- NODE_ADDR, 8'h01, command byte this node answers to; must be nonzero.
- KEY, 8'h37, checksum key; must match the arbiter's key.
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); minimum 4.

Ports:
- clk  in  1  system clock; every state change happens on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_bus  in  1  serial input from the arbiter's tx; idles high.
- sensor_data  in  8  current sensor sample.
- alarm_in  in  1  alarm request; level input.
- tx_bus  out  1  serial output to the arbiter's rx; idles high.
- busy  out  1  high from reply capture until the last stop bit ends.
- frame_err  out  1  one-cycle pulse when a received stop bit samples low.
- cmd_drop  out  1  one-cycle pulse when a matching command arrives while busy.

## Operation
- Reset values: tx_bus=1, busy=0, frame_err=0, cmd_drop=0. Reset also clears the alarm latch, the receiver FSM and the transmitter FSM.
- rx_bus passes through a 2-FF synchronizer. All references to rx below mean the synchronized value.
- Receiver FSM:
  - R_IDLE → R_START on an rx falling edge.
  - R_START waits CLKS_PER_BIT/2 cycles. If rx is low → R_DATA; if rx is high (glitch) → R_IDLE.
  - R_DATA samples 8 bits, LSB first, each CLKS_PER_BIT cycles apart.
  - R_STOP samples after another CLKS_PER_BIT. High → byte valid; low → frame_err pulse, byte discarded. Either way → R_IDLE.
  - The receiver keeps running while busy.
- Command decode on a valid byte:
  - Byte 0x00 or byte ≠ NODE_ADDR: ignored.
  - Match while busy=1: cmd_drop pulse, reply unchanged.
  - Match while busy=0: capture the reply and set busy.
- Reply capture, in the same cycle as the match:
  - Alarm latched → reply pair (0x00, KEY).
  - Otherwise d = sensor_data, with 0x00 replaced by 0x01 so data never aliases the alarm pair. Reply pair is (d, d^KEY).
- Transmitter FSM:
  - T_IDLE → T_GAP: tx held high for CLKS_PER_BIT cycles of turnaround.
  - T_START (low), then T_DATA (8 bits, LSB first), then T_STOP (high). Each bit lasts CLKS_PER_BIT cycles.
  - After the first stop bit, go to T_START for the second byte. After the second stop bit, go to T_IDLE, clear busy, and clear the alarm latch if an alarm pair was sent.
- Alarm latch: set on any cycle where alarm_in=1 (subject to configuration). Cleared only after an alarm pair has been fully sent. alarm_in rising during a data reply does not alter that reply; it is sent on the next matching command.
- Reset asserted mid-frame: tx_bus goes high immediately and any partial reply is abandoned.

## Timing
- Byte validity is decided mid-stop-bit, i.e. about 9.5 bit times plus 2 synchronizer cycles after the start-bit edge.
- Capture cycle = the cycle the byte validates. busy rises on the next edge.
- First start bit begins CLKS_PER_BIT cycles after busy rises.
- The full reply occupies 1 + 20 bit times. busy falls on the edge after the second stop bit completes.
- A frame_err pulse and a match cannot occur for the same byte.
- cmd_drop and frame_err are exactly one clk wide.

## Configuration
- NODE_ALARM_EN defined:
  - Alarm latch present.
  - Alarm pair has priority over data.
  - The 0x00→0x01 substitution is applied.
- Undefined:
  - alarm_in is ignored and no latch exists.
  - Replies are always (d, d^KEY); 0x00 is still substituted by 0x01.

## Test plan
Benches run with CLKS_PER_BIT=16.
- Reset mid-reply: assert reset during the 5th data bit of the first byte → tx_bus=1 within the reset, busy=0; after release, the next command yields a complete fresh reply.
- Matching command: send 0x01 with sensor_data=0x5A → tx frames 0x5A then 0x6D, busy high for exactly 21*16 cycles.
- Non-matching command: send 0x02, then 0x00 → no tx activity, busy stays 0.
- Alarm: pulse alarm_in for 1 cycle, then send 0x01 → frames 0x00, 0x37. A second 0x01 → data reply (latch cleared).
- Zero sample: sensor_data=0x00 with no alarm, send 0x01 → frames 0x01, 0x36.
- Errors: send 0x01 with its stop bit forced low → one frame_err pulse and no reply. Send 0x01 twice back-to-back → second triggers one cmd_drop pulse and only one reply is transmitted.
